fetch_sequencer: RTL

Multi-cycle instruction-fetch controller for the RV32 core.
- Issues fetch requests to instruction memory over a valid/ready handshake.
- Captures the returned word into an instruction register that drives the decoder and the immediate generator.
- Holds that word until the execute side accepts it, and applies branch/jump redirects, discarding any fetch already in flight.

---
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-side bus bundle between the fetch sequencer, instruction memory and the execute side.
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr   fetch request handshake
//   imem_rsp_valid/imem_rsp_data              single-cycle read response
//   instr_valid/instr/instr_pc/instr_ready    instruction register handshake to decode
//   redirect_valid/redirect_pc                taken branch/jump target
//   fetch_fault                               misaligned redirect trap flag
// Modports: master = sequencer side, slave = memory/pipeline side.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle RV32 instruction-fetch controller (IDLE -> REQ -> WAIT -> HOLD).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_sequencer_if.master: imem request/response, instruction register
//          handshake to decode, branch/jump redirect, fetch_fault
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets in a FAULT state; otherwise targets are forced word-aligned and
// fetch_fault is tied low.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            kill;
    logic [XLEN-1:0] target;
    // Where a redirect lands, and where a killed response lands once it drains.
    logic [2:0]      redir_state;
    logic [2:0]      drop_state;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] FAULT = 3'd4;
    logic fault;
    logic misaligned;
    assign target      = bus.redirect_pc;
    assign misaligned  = target[1:0] != 2'b00;
    assign redir_state = misaligned ? FAULT : REQ;
    assign drop_state  = fault ? FAULT : REQ;
    assign bus.fetch_fault = fault;
    // fault tracks the latest redirect; it survives a pending kill in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault <= 1'b0;
        else if (bus.redirect_valid)
            fault <= misaligned;
    end
`else
    assign target      = bus.redirect_pc & ~XLEN'(3);
    assign redir_state = REQ;
    assign drop_state  = REQ;
    assign bus.fetch_fault = 1'b0;
`endif

    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_addr      = pc;
    assign bus.instr_valid    = state == HOLD;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= NOP;
            instr_pc_q <= '0;
            kill       <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc <= target;
            if (state == REQ && bus.imem_req_ready) begin
                // The request just accepted is for the old path; drain it.
                kill  <= 1'b1;
                state <= WAIT;
            end else if (state == WAIT) begin
                kill  <= !bus.imem_rsp_valid;
                state <= bus.imem_rsp_valid ? redir_state : WAIT;
            end else begin
                state <= redir_state;
            end
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ:  if (bus.imem_req_ready) state <= WAIT;
                WAIT: if (bus.imem_rsp_valid) begin
                    if (kill) begin
                        kill  <= 1'b0;
                        state <= drop_state;
                    end else begin
                        instr_q    <= bus.imem_rsp_data;
                        instr_pc_q <= pc;
                        pc         <= pc + XLEN'(4);
                        state      <= HOLD;
                    end
                end
                HOLD: if (bus.instr_ready) state <= REQ;
                default: ;
            endcase
        end
    end
endmodule
